// File: rtl/spi_periph_regfile_if.sv
// SPI responder pins and local register-port signals for spi_periph_regfile.
// The local port is a strobe interface: loc_we is a one-cycle write pulse
// with loc_addr/loc_wdata valid in the same cycle. There is no back-pressure,
// so every strobe is accepted. loc_rdata follows loc_addr one cycle later.
interface spi_periph_regfile_if;
    logic       SS_n;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic       MISO_oe;
    logic       IRQ_n;
    logic [4:0] loc_addr;
    logic       loc_we;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;

    modport master (
        output SS_n, SCLK, MOSI, loc_addr, loc_we, loc_wdata,
        input  MISO, MISO_oe, IRQ_n, loc_rdata
    );

    modport slave (
        input  SS_n, SCLK, MOSI, loc_addr, loc_we, loc_wdata,
        output MISO, MISO_oe, IRQ_n, loc_rdata
    );
endinterface

// File: rtl/spi_periph_regfile.sv
// SPI mode-0 responder in front of a 32 x 8 register file, emulating a
// MAX3421E-style register map. Command byte: R[4:0], 0, DIR, ACKSTAT.
// The status byte (HIRQ) is shifted out during every command byte.
// HIRQ is write-1-to-clear from SPI and OR-set from the local port.
module spi_periph_regfile #(
    parameter int CLK_PER_SCLK_MIN = 8,
    parameter int IRQ_ADDR         = 25,
    parameter int IEN_ADDR         = 26
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    spi_periph_regfile_if.slave  bus,
    output logic [1:0]           state_dbg
);

    localparam logic [4:0] IRQ_A = 5'(IRQ_ADDR);
    localparam logic [4:0] IEN_A = 5'(IEN_ADDR);

    // Two-flop synchronisers plus one edge stage need SCLK half periods of
    // at least three Clk cycles.
    if (CLK_PER_SCLK_MIN < 6) begin : g_ratio_check
        $error("spi_periph_regfile: SCLK too fast for the synchronisers");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] regs      [32];
    logic [7:0] regs_next [32];

    logic       ss_s1, ss_s2, ss_q;
    logic       sclk_s1, sclk_s2, sclk_q;
    logic       mosi_s1, mosi_s2;
    logic [1:0] sync_fill;
    logic       armed;

    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] shift_out;
    logic [4:0] addr;
    logic       dir;
    logic       miso;
    logic       miso_oe;
    logic       wr_pend;
    logic [7:0] wr_data;
    logic       irq_n;
    logic [7:0] loc_rdata;

    logic       ss_fall, ss_rise, sclk_rise, sclk_fall, byte_done;
    logic [7:0] byte_in;

    // Synchronise the SPI pins. 'armed' blocks a select that was already
    // active across reset until SS_n has been seen high again.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            {ss_s1, ss_s2, ss_q}       <= 3'b111;
            {sclk_s1, sclk_s2, sclk_q} <= 3'b000;
            {mosi_s1, mosi_s2}         <= 2'b00;
            sync_fill                  <= 2'd0;
            armed                      <= 1'b0;
        end else begin
            ss_s1   <= bus.SS_n;
            ss_s2   <= ss_s1;
            ss_q    <= ss_s2;
            sclk_s1 <= bus.SCLK;
            sclk_s2 <= sclk_s1;
            sclk_q  <= sclk_s2;
            mosi_s1 <= bus.MOSI;
            mosi_s2 <= mosi_s1;
            if (sync_fill != 2'd2) sync_fill <= sync_fill + 2'd1;
            armed   <= armed | ((sync_fill == 2'd2) & ss_s2);
        end
    end

    assign ss_fall   = armed & ss_q & ~ss_s2;
    assign ss_rise   = ~ss_q & ss_s2;
    assign sclk_rise = sclk_s2 & ~sclk_q;
    assign sclk_fall = ~sclk_s2 & sclk_q;
    assign byte_in   = {shift_in, mosi_s2};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);

    // Transaction FSM: command decode, shift-out, and SPI write capture.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            shift_out <= 8'd0;
            addr      <= 5'd0;
            dir       <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            wr_pend   <= 1'b0;
            wr_data   <= 8'd0;
        end else begin
            wr_pend <= 1'b0;
            if (ss_rise) begin
                state   <= IDLE;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        miso_oe <= 1'b0;
                        miso    <= 1'b0;
                        if (ss_fall) begin
                            state     <= CMD;
                            miso_oe   <= 1'b1;
                            shift_out <= regs[IRQ_A];
                            miso      <= regs[IRQ_A][7];
                            bit_cnt   <= 3'd0;
                        end
                    end
                    CMD, DATA: begin
                        if (sclk_rise) begin
                            shift_in <= byte_in[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                        // After k rises in a byte the next bit out is 7-k.
                        if (sclk_fall) miso <= shift_out[3'd7 - bit_cnt];
                        if (byte_done) begin
                            if (state == CMD) begin
                                addr      <= byte_in[7:3];
                                dir       <= byte_in[1];
                                state     <= DATA;
                                shift_out <= byte_in[1] ? 8'h00 : regs[byte_in[7:3]];
                            end else if (dir) begin
                                wr_pend   <= 1'b1;
                                wr_data   <= byte_in;
                                shift_out <= 8'h00;
                            end else begin
                                shift_out <= regs[addr];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Merge local and SPI writes. On HIRQ a local set is applied after the
    // SPI clear so no event is lost; elsewhere the SPI write is applied last.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_next[i] = regs[i];
            if (5'(i) == IRQ_A) begin
                if (wr_pend && addr == IRQ_A)
                    regs_next[i] = regs_next[i] & ~wr_data;
                if (bus.loc_we && bus.loc_addr == IRQ_A)
                    regs_next[i] = regs_next[i] | bus.loc_wdata;
            end else begin
                if (bus.loc_we && bus.loc_addr == 5'(i))
                    regs_next[i] = bus.loc_wdata;
                if (wr_pend && addr == 5'(i))
                    regs_next[i] = wr_data;
            end
        end
    end

    // Register file, local read-back (pre-write value) and registered IRQ.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 8'd0;
            loc_rdata <= 8'd0;
            irq_n     <= 1'b1;
        end else begin
            for (int i = 0; i < 32; i++) regs[i] <= regs_next[i];
            loc_rdata <= regs[bus.loc_addr];
            irq_n     <= ~|(regs[IRQ_A] & regs[IEN_A]);
        end
    end

    assign bus.MISO      = miso;
    assign bus.MISO_oe   = miso_oe;
    assign bus.IRQ_n     = irq_n;
    assign bus.loc_rdata = loc_rdata;
    assign state_dbg     = state;

endmodule

// File: doc/spi_periph_regfile.md
Name: spi_periph_regfile

Overview:
SPI responder (peripheral) that emulates a MAX3421E-style USB host controller register interface. It is the far end of the SoC's spi0 initiator and lets us bring up and verify the NIOS USB driver path in simulation and on-board without the shield fitted. It holds a 32 x 8 register file. SPI accesses use the command-byte protocol: R[4:0], 0, DIR, ACKSTAT. A local port lets fabric logic read the registers and raise interrupt bits.

Parameters:
CLK_PER_SCLK_MIN, 8, minimum Clk cycles per SCLK period the block must tolerate (SCLK ≤ Clk/8)
IRQ_ADDR, 25, address of the interrupt-flag register (HIRQ); returned as the status byte
IEN_ADDR, 26, address of the interrupt-enable register (HIEN)

Ports:
Clk  input  1  system clock, 50 MHz
Reset_n  input  1  synchronous active-low reset
SS_n  input  1  SPI chip select, asynchronous to Clk, active low
SCLK  input  1  SPI clock, asynchronous, mode 0 (CPOL=0, CPHA=0)
MOSI  input  1  SPI data in, MSB first
MISO  output  1  SPI data out, MSB first
MISO_oe  output  1  MISO output enable (1 while selected)
IRQ_n  output  1  interrupt, active low, registered
loc_addr  input  5  local register address
loc_we  input  1  local write strobe
loc_wdata  input  8  local write data
loc_rdata  output  8  reg[loc_addr], registered, 1-cycle latency

Behaviour:
- Synchronisation: SS_n, SCLK and MOSI each pass through 2 flops. Edges are detected on the synchronised signals: SCLK rise and fall, SS_n fall and rise.
- Reset (Reset_n=0 at a Clk edge):
  - all 32 registers cleared to 0x00; loc_rdata=0; MISO=0; MISO_oe=0; IRQ_n=1; FSM to IDLE.
  - Synchronisers load their idle values (SS_n=1, SCLK=0).
  - Reset takes effect mid-transaction. The transaction is then ignored until SS_n is deasserted and reasserted.
- FSM states: IDLE, CMD, DATA.
- IDLE:
  - MISO_oe=0.
  - On an SS_n fall, go to CMD, set MISO_oe=1, load the shift-out register with reg[IRQ_ADDR], and drive its MSB on MISO within 3 Clk of the synchronised fall.
- CMD:
  - Sample MOSI on each SCLK rise; advance MISO on each SCLK fall.
  - On the 8th rise, latch addr=cmd[7:3] and dir=cmd[1]; cmd[2] and cmd[0] are ignored.
  - For a read (dir=0), load reg[addr] into the shift-out register for the following byte.
  - Go to DATA with the bit counter reset.
- DATA:
  - Each 8-bit byte completes on the 8th SCLK rise.
  - The address does not auto-increment.
  - Write (dir=1):
    - The byte is committed 1 Clk after the 8th-rise detect.
    - At addr==IRQ_ADDR the write is write-1-to-clear: reg &= ~data.
    - At any other address the byte overwrites reg[addr].
    - MISO shifts out 0x00.
  - Read (dir=0): every byte returns the current reg[addr], reloaded at each byte boundary.
- SS_n rise in any state:
  - go to IDLE next cycle; MISO_oe=0, MISO=0.
  - A partial byte (<8 bits) is discarded with no write; the bit counter is cleared.
- Local port:
  - loc_we=1 at loc_addr==IRQ_ADDR ORs loc_wdata into HIRQ (sets flags).
  - At any other address, loc_we=1 overwrites the register.
  - loc_rdata is updated every cycle from reg[loc_addr] as it was before this cycle's writes.
- Simultaneous access, same register, same Clk:
  - HIRQ: a local set beats an SPI clear on the same bit, so no event is lost. Other bits clear normally.
  - Any other register: the SPI write wins.
- Interrupt: IRQ_n = ~|(reg[IRQ_ADDR] & reg[IEN_ADDR]), registered, so it updates 1 Clk after the register change.
- Bit counter: 3 bits, wraps from 7 to 0 at each byte boundary. Unlimited bytes per SS_n assertion.

Test Plan:
1. Reset -> with Reset_n low for 2 cycles mid-transfer: all regs 0x00, IRQ_n=1, MISO_oe=0. A following SPI transaction decodes correctly.
2. SPI write 0x42 (addr 8, write), then 0xA5 -> MISO returns 0x00 during the command byte; loc_addr=8 yields loc_rdata=0xA5 on the next cycle.
3. Local write reg5=0x3C, then SPI 0x28 plus two data bytes -> MISO returns 0x3C, 0x3C; reg5 is unchanged.
4. Local write reg25=0x04 and reg26=0x04 -> IRQ_n=0. The next command byte returns 0x04 on MISO. SPI 0xCA then 0x04 -> HIRQ=0x00 and IRQ_n=1.
5. SPI 0x1A (addr 3, write), then 5 data bits, then SS_n raised -> reg3 unchanged. The next transaction 0x18 reads reg3 correctly.
6. Same cycle, HIRQ=0x06: SPI clear 0x06 and local set 0x02 -> HIRQ=0x02, IRQ_n follows the enable state.
